// File: rtl/nios_fprint_jtag_scan_master.sv
// Virtual-JTAG scan master: runs UIR/CDR/SDR/UDR/RTI on a divided tck and returns the captured DR.
// Optional build macro NIOS_FPRINT_SCAN_SKIP_IR_EN skips UIR when the IR matches the last issued IR.
module nios_fprint_jtag_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_rti,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic [1:0]          vji_ir_in,
  input  logic                vji_tdo
);

  // state | meaning
  // IDLE  | waiting for a command, tck parked low
  // UIR   | one tck period presenting the new IR
  // CDR   | one tck period capture-DR
  // SDR   | DR_WIDTH tck periods shifting tdi out / tdo in
  // UDR   | one tck period update-DR
  // RTI   | one tck period run-test-idle before the response
  // RESP  | captured word held until rsp_ready
  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
  } state_t;

  localparam int PW = $clog2(2 * TCK_DIV);
  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(2 * TCK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(TCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

  state_t              state_q, state_d;
  logic [PW-1:0]       ph_q, ph_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic [1:0]          ir_q;
  logic                tdi_q;
  logic                accept, active, period_end, sample, skip_uir, tdi_load;

`ifdef NIOS_FPRINT_SCAN_SKIP_IR_EN
  logic last_ir_vld;

  assign skip_uir = last_ir_vld && (cmd_ir == ir_q);

  always_ff @(posedge clk) begin
    if (reset) last_ir_vld <= 1'b0;
    else if (accept) last_ir_vld <= 1'b1;
  end
`else
  assign skip_uir = 1'b0;
`endif

  assign accept     = (state_q == S_IDLE) && cmd_valid;
  assign active     = (state_q != S_IDLE) && (state_q != S_RESP);
  assign period_end = (ph_q == '0);
  assign sample     = (state_q == S_SDR) && (ph_q == PH_RISE);
  // tdi moves only at the start of a low tck phase inside SDR
  assign tdi_load   = period_end && ((state_q == S_CDR) || ((state_q == S_SDR) && (bit_q != '0)));

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    if (active) ph_d = period_end ? PH_LAST : ph_q - 1'b1;
    if (sample) sr_d = {vji_tdo, sr_q[DR_WIDTH-1:1]};
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        state_d = skip_uir ? S_CDR : S_UIR;
        ph_d    = PH_LAST;
        bit_d   = BIT_LAST;
        sr_d    = cmd_dr;
      end
      S_UIR:  if (period_end) state_d = S_CDR;
      S_CDR:  if (period_end) state_d = S_SDR;
      S_SDR:  if (period_end) begin
        if (bit_q == '0) state_d = S_UDR;
        else bit_d = bit_q - 1'b1;
      end
      S_UDR:  if (period_end) state_d = S_RTI;
      S_RTI:  if (period_end) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      ir_q    <= '0;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      if (accept) ir_q <= cmd_ir;
      if (tdi_load) tdi_q <= sr_d[0];
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_dr    = rsp_valid ? sr_q : '0;
  assign vji_tck   = active && (ph_q <= PH_RISE);
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_rti   = (state_q == S_IDLE) || (state_q == S_RTI) || (state_q == S_RESP);
  assign vji_uir   = (state_q == S_UIR);
  assign vji_cdr   = (state_q == S_CDR);
  assign vji_sdr   = (state_q == S_SDR);
  assign vji_udr   = (state_q == S_UDR);

endmodule
